// File: rtl/reflex_round_if.sv
// Signal bundle between the reaction-game round sequencer and the button/display logic.
// The slave side is the sequencer; the master side drives start/btn and observes results.
interface reflex_round_if;
  logic        start;
  logic        btn;
  logic        go_led;
  logic        busy;
  logic [11:0] result_ms;
  logic        result_valid;
  logic        foul;
  logic        timeout;
  logic        blink;
  logic [11:0] best_ms;

  modport master (
    output start, btn,
    input  go_led, busy, result_ms, result_valid, foul, timeout, blink, best_ms
  );

  modport slave (
    input  start, btn,
    output go_led, busy, result_ms, result_valid, foul, timeout, blink, best_ms
  );
endinterface

// File: rtl/reflex_round_ctrl.sv
// Reaction-game round sequencer: random pre-GO delay, ms reaction timer, foul/timeout, blink.
// Define REFLEX_BEST_EN to build the best-reaction tracker; otherwise best_ms is tied to 12'hFFF.
module reflex_round_ctrl #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 10,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter int unsigned BLINK_MS     = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  reflex_round_if.slave bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DlyW = 17;
  localparam int unsigned BlkW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StGo, StDone} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            btn_q;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [11:0]     rcnt_q, rcnt_d;
  logic [BlkW-1:0] bcnt_q, bcnt_d;
  logic            go_led_q, go_led_d;
  logic            busy_q, busy_d;
  logic [11:0]     result_ms_q, result_ms_d;
  logic            result_valid_q, result_valid_d;
  logic            foul_q, foul_d;
  logic            timeout_q, timeout_d;
  logic            blink_q, blink_d;

  logic tick, press, enter_arm, enter_go, go_timeout;

  assign tick       = (pre_q == PreW'(TICK_DIV - 1));
  // Rising edge only: a button already held when the round starts must be released first.
  assign press      = bus.btn & ~btn_q;
  assign go_timeout = tick && (rcnt_q == 12'(TIMEOUT_MS - 1));
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pre_q          <= '0;
      lfsr_q         <= 16'hACE1;
      btn_q          <= 1'b0;
      dly_q          <= '0;
      rcnt_q         <= '0;
      bcnt_q         <= '0;
      go_led_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_ms_q    <= '0;
      result_valid_q <= 1'b0;
      foul_q         <= 1'b0;
      timeout_q      <= 1'b0;
      blink_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      lfsr_q         <= lfsr_d;
      btn_q          <= bus.btn;
      dly_q          <= dly_d;
      rcnt_q         <= rcnt_d;
      bcnt_q         <= bcnt_d;
      go_led_q       <= go_led_d;
      busy_q         <= busy_d;
      result_ms_q    <= result_ms_d;
      result_valid_q <= result_valid_d;
      foul_q         <= foul_d;
      timeout_q      <= timeout_d;
      blink_q        <= blink_d;
    end
  end

  // Next-state logic; a press beats the GO and timeout transitions in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.start) state_d = StArm;
      StArm: begin
        if (press) begin
          state_d = StDone;
        end else if (tick && (dly_q == DlyW'(1))) begin
          state_d = StGo;
        end
      end
      StGo:   if (press || go_timeout) state_d = StDone;
      StDone: if (bus.start) state_d = StArm;
      default: state_d = StIdle;
    endcase
  end

  assign enter_arm = (state_d == StArm) && (state_q != StArm);
  assign enter_go  = (state_d == StGo) && (state_q != StGo);

  // Datapath and registered outputs, all computed from the upcoming state.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PreW'(1);
    if (enter_arm || enter_go) pre_d = '0;

    dly_d = dly_q;
    if (enter_arm) begin
      dly_d = DlyW'(MIN_DELAY_MS) + DlyW'(lfsr_q[RAND_BITS-1:0]);
    end else if ((state_q == StArm) && tick) begin
      dly_d = dly_q - DlyW'(1);
    end

    rcnt_d = rcnt_q;
    if (enter_go) begin
      rcnt_d = '0;
    end else if ((state_q == StGo) && tick) begin
      rcnt_d = rcnt_q + 12'd1;
    end

    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if ((state_q != StDone) || (state_d != StDone)) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BlkW'(BLINK_MS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BlkW'(1);
      end
    end

    go_led_d       = (state_d == StGo);
    busy_d         = (state_d == StArm) || (state_d == StGo);
    result_valid_d = (state_q == StGo) && press;

    result_ms_d = result_ms_q;
    if (state_q == StGo) begin
      if (press) begin
        result_ms_d = rcnt_q;
      end else if (go_timeout) begin
        result_ms_d = 12'(TIMEOUT_MS);
      end
    end

    foul_d    = foul_q;
    timeout_d = timeout_q;
    if (enter_arm) begin
      foul_d    = 1'b0;
      timeout_d = 1'b0;
    end else if ((state_q == StArm) && press) begin
      foul_d = 1'b1;
    end else if ((state_q == StGo) && !press && go_timeout) begin
      timeout_d = 1'b1;
    end
  end

  assign bus.go_led       = go_led_q;
  assign bus.busy         = busy_q;
  assign bus.result_ms    = result_ms_q;
  assign bus.result_valid = result_valid_q;
  assign bus.foul         = foul_q;
  assign bus.timeout      = timeout_q;
  assign bus.blink        = blink_q;

`ifdef REFLEX_BEST_EN
  logic [11:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (result_valid_d && (result_ms_d < best_q)) best_d = result_ms_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= 12'hFFF;
    end else begin
      best_q <= best_d;
    end
  end

  assign bus.best_ms = best_q;
`else
  assign bus.best_ms = 12'hFFF;
`endif

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Directed bench for reflex_round_ctrl with a scoreboard of expected round outcomes.
module tb_reflex_round_ctrl;
  localparam int unsigned TickDiv   = 10;
  localparam int unsigned MinDly    = 5;
  localparam int unsigned RandBits  = 2;
  localparam int unsigned TimeoutMs = 20;
  localparam int unsigned BlinkMs   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reflex_round_if bus ();

  reflex_round_ctrl #(
    .TICK_DIV    (TickDiv),
    .MIN_DELAY_MS(MinDly),
    .RAND_BITS   (RandBits),
    .TIMEOUT_MS  (TimeoutMs),
    .BLINK_MS    (BlinkMs)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [11:0] ms;
    logic        foul;
    logic        tmo;
    logic        valid;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_dly = 0;
  int          w;
  logic        seen;
  logic [15:0] m_lfsr;
  logic [11:0] m_best;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed 16'hACE1, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s_go_led", tag), bus.go_led, 0);
    check($sformatf("%s_busy", tag), bus.busy, 0);
    check($sformatf("%s_result_ms", tag), bus.result_ms, 0);
    check($sformatf("%s_result_valid", tag), bus.result_valid, 0);
    check($sformatf("%s_foul", tag), bus.foul, 0);
    check($sformatf("%s_timeout", tag), bus.timeout, 0);
    check($sformatf("%s_blink", tag), bus.blink, 0);
    check($sformatf("%s_best_ms", tag), bus.best_ms, 12'hFFF);
  endtask

  task automatic expect_end(input logic [11:0] ms, input logic f, input logic t, input logic v);
    sb_q.push_back({ms, f, t, v});
  endtask

  // Called on a negedge; the following posedge samples start with the current LFSR value.
  task automatic start_round();
    bus.start = 1'b1;
    exp_dly   = int'(MinDly) + int'(m_lfsr[RandBits-1:0]);
    step(1);
    bus.start = 1'b0;
    check("arm_busy", bus.busy, 1);
    check("arm_go_low", bus.go_led, 0);
    check("arm_foul_clr", bus.foul, 0);
    check("arm_tmo_clr", bus.timeout, 0);
    check("arm_blink_clr", bus.blink, 0);
  endtask

  task automatic wait_go();
    int n = 0;
    while (bus.go_led !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("go_delay", n, exp_dly * int'(TickDiv));
    check("go_in_range", (n >= 50 && n <= 80), 1);
  endtask

  // Button rises so that the press is sampled exactly 'edges' clock edges from now.
  task automatic press_at(input int edges, input logic [11:0] ms, input logic f);
    step(edges - 1);
    bus.btn = 1'b1;
    expect_end(ms, f, 1'b0, !f);
    step(1);
  endtask

  task automatic finish_round(input string tag, output int waited);
    exp_t e;
    int   n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    waited = n;
    check($sformatf("%s_sb_nonempty", tag), (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s_result_ms", tag), bus.result_ms, e.ms);
      check($sformatf("%s_foul", tag), bus.foul, e.foul);
      check($sformatf("%s_timeout", tag), bus.timeout, e.tmo);
      check($sformatf("%s_valid", tag), bus.result_valid, e.valid);
      check($sformatf("%s_go_off", tag), bus.go_led, 0);
`ifdef REFLEX_BEST_EN
      if (e.valid && e.ms < m_best) m_best = e.ms;
`endif
      check($sformatf("%s_best", tag), bus.best_ms, m_best);
      step(1);
      check($sformatf("%s_valid_drop", tag), bus.result_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.btn   = 1'b0;
    m_best    = 12'hFFF;
    step(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    step(3);

    // Round 1: valid press 7 ticks after GO.
    start_round();
    wait_go();
    press_at(75, 12'd7, 1'b0);
    finish_round("r1", w);
    check("r1_latency", w, 0);
    bus.btn = 1'b0;

    // Round 2: foul during ARM; result_ms keeps 7, GO never follows.
    start_round();
    press_at(20, 12'd7, 1'b1);
    finish_round("r2", w);
    check("r2_latency", w, 0);
    bus.btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.go_led !== 1'b0) seen = 1'b1;
    end
    check("r2_no_go", seen, 0);

    // Round 3: no press, timeout after the full window, then blink every 3 ticks.
    start_round();
    wait_go();
    expect_end(12'(TimeoutMs), 1'b0, 1'b1, 1'b0);
    finish_round("r3", w);
    check("r3_window", w, TimeoutMs * TickDiv);
    step(28);
    check("blink_pre", bus.blink, 0);
    step(1);
    check("blink_rise", bus.blink, 1);
    step(29);
    check("blink_hold", bus.blink, 1);
    step(1);
    check("blink_fall", bus.blink, 0);
    step(30);
    check("blink_rise2", bus.blink, 1);

    // Round 4: button held through start and GO, released, then pressed at tick 4.
    bus.btn = 1'b1;
    step(2);
    start_round();
    wait_go();
    step(10);
    bus.btn = 1'b0;
    press_at(35, 12'd4, 1'b0);
    finish_round("r4", w);
    check("r4_latency", w, 0);
    bus.btn = 1'b0;

    // Rounds 5 and 6: scores 9 and 6 leave the best at 4.
    start_round();
    wait_go();
    press_at(95, 12'd9, 1'b0);
    finish_round("r5", w);
    bus.btn = 1'b0;
    start_round();
    wait_go();
    press_at(65, 12'd6, 1'b0);
    finish_round("r6", w);
    bus.btn = 1'b0;

    // Round 7: press on the timeout tick counts as a valid reaction.
    start_round();
    wait_go();
    press_at(int'(TimeoutMs * TickDiv), 12'(TimeoutMs - 1), 1'b0);
    finish_round("r7", w);
    check("r7_latency", w, 0);
    bus.btn = 1'b0;

    // Round 8: reset asserted mid-GO.
    start_round();
    wait_go();
    step(30);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midgo");
    check("sb_empty", sb_q.size(), 0);
    m_best = 12'hFFF;
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_go", bus.go_led, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
